ysyx_210544_rf_wb_arbiter: RTL

- Shares the single regfile write port (rd index, write-enable, 64-bit data) between two writeback sources.
  - Source 0: the in-order pipeline writeback.
  - Source 1: the long-latency unit (load/mul/div returns).
- Keeps a 32-entry scoreboard of destination registers with an outstanding long-latency result, and reports read hazards for the decode-stage rs1/rs2 indices.
- Sits between WB/LSU/MDU and the regfile; the hazard outputs feed the decode stall logic.

---
 rtl/ysyx_210544_rf_wb_arbiter_pkg.sv | 12 +
 rtl/ysyx_210544_rf_wb_arbiter_scoreboard.sv | 46 ++++
 rtl/ysyx_210544_rf_wb_arbiter.sv | 113 +++++++++++
 3 files changed

// File: rtl/ysyx_210544_rf_wb_arbiter_pkg.sv
// Shared constants for the regfile writeback arbiter slice.
// Holds the register-index width, data width, regfile depth and the zero word
// used by the arbiter and its scoreboard.
package ysyx_210544_rf_wb_arbiter_pkg;

  localparam int unsigned RIDX_W = 5;
  localparam int unsigned XLEN   = 64;
  localparam int unsigned RF_NUM = 32;

  localparam logic [XLEN-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/ysyx_210544_rf_wb_arbiter_scoreboard.sv
// ysyx_210544_rf_scoreboard: pending-destination vector for long-latency ops.
// Ports:
//   clk, rst          clock, async active-high reset (clears the vector)
//   set_en, set_rd    mark set_rd pending (index 0 is never marked)
//   clr_en, clr_rd    mark clr_rd retired
//   rs1, rs2          hazard query indices
//   rs1_busy, rs2_busy  query results (0 while rst is high)
// A same-cycle set and clear of one index leaves it set.
module ysyx_210544_rf_scoreboard
  import ysyx_210544_rf_wb_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [RIDX_W-1:0] set_rd,
  input  logic              clr_en,
  input  logic [RIDX_W-1:0] clr_rd,
  input  logic [RIDX_W-1:0] rs1,
  input  logic [RIDX_W-1:0] rs2,
  output logic              rs1_busy,
  output logic              rs2_busy
);

  logic [RF_NUM-1:0] pend;
  logic [RF_NUM-1:0] set_mask;
  logic [RF_NUM-1:0] clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en && (set_rd != '0)) set_mask[set_rd] = 1'b1;
    if (clr_en)                   clr_mask[clr_rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend <= '0;
    else     pend <= (pend & ~clr_mask) | set_mask;
  end

  // The issuing op's mask is folded in so the hazard is visible in the issue cycle.
  always_comb begin
    rs1_busy = !rst && (pend[rs1] || set_mask[rs1]);
    rs2_busy = !rst && (pend[rs2] || set_mask[rs2]);
  end

endmodule

// File: rtl/ysyx_210544_rf_wb_arbiter.sv
// ysyx_210544_rf_wb_arbiter: shares the single regfile write port between the
// in-order writeback (source 0) and the long-latency unit (source 1), and
// tracks outstanding long-latency destinations for decode hazard checks.
// Ports:
//   clk, rst                      clock, async active-high reset
//   i_wb0_valid/rd/data, o_wb0_ready   source 0 request / accept
//   i_wb1_valid/rd/data, o_wb1_ready   source 1 request / accept
//   i_issue_valid, i_issue_rd     long-latency op issue (marks rd pending)
//   i_rs1, i_rs2, o_rs1_busy, o_rs2_busy  decode hazard query
//   o_rd, o_rd_wen, o_rd_data     registered regfile write port
// Optional build macro YSYX_210544_RF_WB_PERF_EN adds:
//   o_conflict_cnt  cycles with both sources requesting (wraps)
//   o_starve_hit    pulse when the starvation override grants source 1
module ysyx_210544_rf_wb_arbiter
  import ysyx_210544_rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 3,
  parameter int unsigned CNT_W        = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wb0_valid,
  input  logic [RIDX_W-1:0] i_wb0_rd,
  input  logic [XLEN-1:0]   i_wb0_data,
  output logic              o_wb0_ready,
  input  logic              i_wb1_valid,
  input  logic [RIDX_W-1:0] i_wb1_rd,
  input  logic [XLEN-1:0]   i_wb1_data,
  output logic              o_wb1_ready,
  input  logic              i_issue_valid,
  input  logic [RIDX_W-1:0] i_issue_rd,
  input  logic [RIDX_W-1:0] i_rs1,
  input  logic [RIDX_W-1:0] i_rs2,
  output logic              o_rs1_busy,
  output logic              o_rs2_busy,
  output logic [RIDX_W-1:0] o_rd,
  output logic              o_rd_wen,
  output logic [XLEN-1:0]   o_rd_data
`ifdef YSYX_210544_RF_WB_PERF_EN
  ,
  output logic [31:0]       o_conflict_cnt,
  output logic              o_starve_hit
`endif
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;
  logic             grant0;
  logic             grant1;

  always_comb begin
    starved = (starve_cnt == LIMIT);
    grant1  = !rst && i_wb1_valid && (!i_wb0_valid || starved);
    grant0  = !rst && i_wb0_valid && !grant1;
  end

  assign o_wb0_ready = grant0;
  assign o_wb1_ready = grant1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (i_wb1_valid && !grant1) begin
      if (!starved) starve_cnt <= starve_cnt + 1'b1;
    end else begin
      starve_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_rd      <= '0;
      o_rd_wen  <= 1'b0;
      o_rd_data <= ZERO_WORD;
    end else if (grant1) begin
      o_rd      <= i_wb1_rd;
      o_rd_wen  <= (i_wb1_rd != '0);
      o_rd_data <= i_wb1_data;
    end else if (grant0) begin
      o_rd      <= i_wb0_rd;
      o_rd_wen  <= (i_wb0_rd != '0);
      o_rd_data <= i_wb0_data;
    end else begin
      o_rd_wen  <= 1'b0;
    end
  end

  ysyx_210544_rf_scoreboard u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (i_issue_valid),
    .set_rd   (i_issue_rd),
    .clr_en   (grant1),
    .clr_rd   (i_wb1_rd),
    .rs1      (i_rs1),
    .rs2      (i_rs2),
    .rs1_busy (o_rs1_busy),
    .rs2_busy (o_rs2_busy)
  );

`ifdef YSYX_210544_RF_WB_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             o_conflict_cnt <= '0;
    else if (i_wb0_valid && i_wb1_valid) o_conflict_cnt <= o_conflict_cnt + 32'd1;
  end

  // Source 1 only wins against a valid source 0 through the override.
  assign o_starve_hit = grant1 && i_wb0_valid;
`endif

endmodule
